// File: rtl/supernova_prf_wb_arbiter_if.sv
// Source-result and PRF-write bundle for the writeback arbiter.
// The producer/testbench side uses master, the arbiter uses slave.
interface supernova_prf_wb_arbiter_if #(
  parameter int NUM_SOURCES     = 6,
  parameter int NUM_WRITE_PORTS = 4,
  parameter int TAG_WIDTH       = 7,
  parameter int DATA_WIDTH      = 64
);
  logic [NUM_SOURCES-1:0]                      src_valid_in;
  logic [NUM_SOURCES-1:0]                      src_ready_out;
  logic [NUM_SOURCES-1:0]                      src_is_fp_in;
  logic [NUM_SOURCES-1:0][TAG_WIDTH-1:0]       src_tag_in;
  logic [NUM_SOURCES-1:0][DATA_WIDTH-1:0]      src_data_in;
  logic [NUM_WRITE_PORTS-1:0]                  gpr_write_valid_out;
  logic [NUM_WRITE_PORTS-1:0][TAG_WIDTH-1:0]   gpr_write_addr_out;
  logic [NUM_WRITE_PORTS-1:0][DATA_WIDTH-1:0]  gpr_write_data_out;
  logic [NUM_WRITE_PORTS-1:0]                  fpr_write_valid_out;
  logic [NUM_WRITE_PORTS-1:0][TAG_WIDTH-1:0]   fpr_write_addr_out;
  logic [NUM_WRITE_PORTS-1:0][DATA_WIDTH-1:0]  fpr_write_data_out;
  logic                                        wb_conflict_out;

  modport master (
    output src_valid_in, src_is_fp_in, src_tag_in, src_data_in,
    input  src_ready_out,
    input  gpr_write_valid_out, gpr_write_addr_out, gpr_write_data_out,
    input  fpr_write_valid_out, fpr_write_addr_out, fpr_write_data_out,
    input  wb_conflict_out
  );

  modport slave (
    input  src_valid_in, src_is_fp_in, src_tag_in, src_data_in,
    output src_ready_out,
    output gpr_write_valid_out, gpr_write_addr_out, gpr_write_data_out,
    output fpr_write_valid_out, fpr_write_addr_out, fpr_write_data_out,
    output wb_conflict_out
  );
endinterface

// File: rtl/supernova_prf_wb_arbiter.sv
// Writeback arbiter: per-source one-entry holding buffers, round-robin grant of
// up to NUM_WRITE_PORTS GPR and NUM_WRITE_PORTS FPR results per cycle, registered PRF ports.

module supernova_prf_wb_buf #(
  parameter int TAG_WIDTH  = 7,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  in_is_fp,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  grant,
  output logic                  ready,
  output logic                  buf_valid,
  output logic                  buf_is_fp,
  output logic [TAG_WIDTH-1:0]  buf_tag,
  output logic [DATA_WIDTH-1:0] buf_data
);
  assign ready = !buf_valid | grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid <= 1'b0;
      buf_is_fp <= 1'b0;
      buf_tag   <= '0;
      buf_data  <= '0;
    end else if (in_valid && ready) begin
      buf_valid <= 1'b1;
      buf_is_fp <= in_is_fp;
      buf_tag   <= in_tag;
      buf_data  <= in_data;
    end else if (grant) begin
      buf_valid <= 1'b0;
    end
  end
endmodule

module supernova_prf_wb_arbiter #(
  parameter int NUM_SOURCES     = 6,
  parameter int NUM_WRITE_PORTS = 4,
  parameter int TAG_WIDTH       = 7,
  parameter int DATA_WIDTH      = 64
) (
  input  logic clk,
  input  logic rst,
  supernova_prf_wb_arbiter_if.slave bus
);
  localparam int PTR_W = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;

  logic [NUM_SOURCES-1:0]                 buf_valid, buf_is_fp, grant, ready;
  logic [NUM_SOURCES-1:0][TAG_WIDTH-1:0]  buf_tag;
  logic [NUM_SOURCES-1:0][DATA_WIDTH-1:0] buf_data;
  logic [PTR_W-1:0]                       rr_ptr, first_deny;
  logic                                   deny_any;

  logic [NUM_WRITE_PORTS-1:0]                 g_wv_n, f_wv_n, g_wv_q, f_wv_q;
  logic [NUM_WRITE_PORTS-1:0][TAG_WIDTH-1:0]  g_addr_n, f_addr_n, g_addr_q, f_addr_q;
  logic [NUM_WRITE_PORTS-1:0][DATA_WIDTH-1:0] g_data_n, f_data_n, g_data_q, f_data_q;
  logic                                       conflict_q;

  for (genvar i = 0; i < NUM_SOURCES; i++) begin : g_src
    supernova_prf_wb_buf #(.TAG_WIDTH(TAG_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_buf (
      .clk      (clk),
      .rst      (rst),
      .in_valid (bus.src_valid_in[i]),
      .in_is_fp (bus.src_is_fp_in[i]),
      .in_tag   (bus.src_tag_in[i]),
      .in_data  (bus.src_data_in[i]),
      .grant    (grant[i]),
      .ready    (ready[i]),
      .buf_valid(buf_valid[i]),
      .buf_is_fp(buf_is_fp[i]),
      .buf_tag  (buf_tag[i]),
      .buf_data (buf_data[i])
    );
  end

  // Circular scan from rr_ptr; GPR and FPR fill their own port lists.
  // GPR tag 0 is the hardwired zero register: freed without using a port.
  always_comb begin
    int idx, gcnt, fcnt;
    idx        = 0;
    gcnt       = 0;
    fcnt       = 0;
    grant      = '0;
    deny_any   = 1'b0;
    first_deny = '0;
    g_wv_n     = '0;
    g_addr_n   = '0;
    g_data_n   = '0;
    f_wv_n     = '0;
    f_addr_n   = '0;
    f_data_n   = '0;
    for (int k = 0; k < NUM_SOURCES; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_SOURCES) idx = idx - NUM_SOURCES;
      if (buf_valid[idx]) begin
        if (!buf_is_fp[idx] && buf_tag[idx] == '0) begin
          grant[idx] = 1'b1;
        end else if (!buf_is_fp[idx] && gcnt < NUM_WRITE_PORTS) begin
          grant[idx]     = 1'b1;
          g_wv_n[gcnt]   = 1'b1;
          g_addr_n[gcnt] = buf_tag[idx];
          g_data_n[gcnt] = buf_data[idx];
          gcnt++;
        end else if (buf_is_fp[idx] && fcnt < NUM_WRITE_PORTS) begin
          grant[idx]     = 1'b1;
          f_wv_n[fcnt]   = 1'b1;
          f_addr_n[fcnt] = buf_tag[idx];
          f_data_n[fcnt] = buf_data[idx];
          fcnt++;
        end else if (!deny_any) begin
          deny_any   = 1'b1;
          first_deny = PTR_W'(idx);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr     <= '0;
      g_wv_q     <= '0;
      g_addr_q   <= '0;
      g_data_q   <= '0;
      f_wv_q     <= '0;
      f_addr_q   <= '0;
      f_data_q   <= '0;
      conflict_q <= 1'b0;
    end else begin
      if (deny_any) rr_ptr <= first_deny;
      g_wv_q     <= g_wv_n;
      f_wv_q     <= f_wv_n;
      conflict_q <= deny_any;
      // Idle ports keep their last addr/data to avoid needless toggling.
      for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
        if (g_wv_n[p]) begin
          g_addr_q[p] <= g_addr_n[p];
          g_data_q[p] <= g_data_n[p];
        end
        if (f_wv_n[p]) begin
          f_addr_q[p] <= f_addr_n[p];
          f_data_q[p] <= f_data_n[p];
        end
      end
    end
  end

  assign bus.src_ready_out       = ready;
  assign bus.gpr_write_valid_out = g_wv_q;
  assign bus.gpr_write_addr_out  = g_addr_q;
  assign bus.gpr_write_data_out  = g_data_q;
  assign bus.fpr_write_valid_out = f_wv_q;
  assign bus.fpr_write_addr_out  = f_addr_q;
  assign bus.fpr_write_data_out  = f_data_q;
  assign bus.wb_conflict_out     = conflict_q;
endmodule

// File: tb/tb_supernova_prf_wb_arbiter.sv
// Directed bench for the writeback arbiter; hand-computed expectations.
module tb_supernova_prf_wb_arbiter;
  localparam int NS = 6;
  localparam int NP = 4;
  localparam int TW = 7;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  supernova_prf_wb_arbiter_if #(.NUM_SOURCES(NS), .NUM_WRITE_PORTS(NP),
    .TAG_WIDTH(TW), .DATA_WIDTH(DW)) bus ();

  supernova_prf_wb_arbiter #(.NUM_SOURCES(NS), .NUM_WRITE_PORTS(NP),
    .TAG_WIDTH(TW), .DATA_WIDTH(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_src();
    bus.src_valid_in = '0;
    bus.src_is_fp_in = '0;
    bus.src_tag_in   = '0;
    bus.src_data_in  = '0;
  endtask

  task automatic offer(input int i, input logic fp, input logic [TW-1:0] tag, input logic [DW-1:0] data);
    bus.src_valid_in[i] = 1'b1;
    bus.src_is_fp_in[i] = fp;
    bus.src_tag_in[i]   = tag;
    bus.src_data_in[i]  = data;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_src();
    step();
    rst = 1'b0;
  endtask

  initial begin
    clear_src();
    step();
    step();
    rst = 1'b0;

    // Reset state
    chk("rst_ready",    64'(bus.src_ready_out), 64'h3F);
    chk("rst_gpr_v",    64'(bus.gpr_write_valid_out), 64'h0);
    chk("rst_fpr_v",    64'(bus.fpr_write_valid_out), 64'h0);
    chk("rst_gpr_addr", 64'(bus.gpr_write_addr_out), 64'h0);
    chk("rst_conflict", 64'(bus.wb_conflict_out), 64'h0);

    // Single source: src 2, GPR tag 5, data 0xAB
    offer(2, 1'b0, 7'd5, 64'hAB);
    chk("single_ready_c0", 64'(bus.src_ready_out[2]), 64'h1);
    step();
    clear_src();
    chk("single_ready_c1", 64'(bus.src_ready_out[2]), 64'h1);
    chk("single_gpr_v_c1", 64'(bus.gpr_write_valid_out), 64'h0);
    step();
    chk("single_gpr_v",    64'(bus.gpr_write_valid_out), 64'h1);
    chk("single_addr0",    64'(bus.gpr_write_addr_out[0]), 64'd5);
    chk("single_data0",    bus.gpr_write_data_out[0], 64'hAB);
    chk("single_fpr_v",    64'(bus.fpr_write_valid_out), 64'h0);
    chk("single_conflict", 64'(bus.wb_conflict_out), 64'h0);
    chk("single_ready_c2", 64'(bus.src_ready_out[2]), 64'h1);
    step();
    chk("single_gpr_v_c3", 64'(bus.gpr_write_valid_out), 64'h0);
    chk("single_addr_hold", 64'(bus.gpr_write_addr_out[0]), 64'd5);

    // Contention: all six GPR, tags 1..6, held every cycle
    do_reset();
    for (int i = 0; i < NS; i++) offer(i, 1'b0, TW'(i + 1), DW'(64'h10 + i));
    step();
    chk("cont_ready_c1", 64'(bus.src_ready_out), 64'h0F);
    step();
    chk("cont_gpr_v_c2",  64'(bus.gpr_write_valid_out), 64'hF);
    chk("cont_addr_c2",   64'(bus.gpr_write_addr_out), 64'({7'd4, 7'd3, 7'd2, 7'd1}));
    chk("cont_data0_c2",  bus.gpr_write_data_out[0], 64'h10);
    chk("cont_data3_c2",  bus.gpr_write_data_out[3], 64'h13);
    chk("cont_conf_c2",   64'(bus.wb_conflict_out), 64'h1);
    chk("cont_ready_c2",  64'(bus.src_ready_out), 64'h33);
    step();
    chk("cont_addr_c3",   64'(bus.gpr_write_addr_out), 64'({7'd2, 7'd1, 7'd6, 7'd5}));
    chk("cont_data0_c3",  bus.gpr_write_data_out[0], 64'h14);
    chk("cont_conf_c3",   64'(bus.wb_conflict_out), 64'h1);
    chk("cont_ready_c3",  64'(bus.src_ready_out), 64'h3C);
    step();
    chk("cont_addr_c4",   64'(bus.gpr_write_addr_out), 64'({7'd6, 7'd5, 7'd4, 7'd3}));
    chk("cont_gpr_v_c4",  64'(bus.gpr_write_valid_out), 64'hF);

    // Mixed classes: 0-3 GPR tags 10..13, 4-5 FPR tags 20,21
    do_reset();
    for (int i = 0; i < 4; i++) offer(i, 1'b0, TW'(10 + i), DW'(64'h100 + i));
    offer(4, 1'b1, 7'd20, 64'h200);
    offer(5, 1'b1, 7'd21, 64'h201);
    step();
    clear_src();
    chk("mix_ready_c1", 64'(bus.src_ready_out), 64'h3F);
    step();
    chk("mix_gpr_v",    64'(bus.gpr_write_valid_out), 64'hF);
    chk("mix_gpr_addr", 64'(bus.gpr_write_addr_out), 64'({7'd13, 7'd12, 7'd11, 7'd10}));
    chk("mix_fpr_v",    64'(bus.fpr_write_valid_out), 64'h3);
    chk("mix_fpr_a0",   64'(bus.fpr_write_addr_out[0]), 64'd20);
    chk("mix_fpr_a1",   64'(bus.fpr_write_addr_out[1]), 64'd21);
    chk("mix_fpr_d1",   bus.fpr_write_data_out[1], 64'h201);
    chk("mix_conflict", 64'(bus.wb_conflict_out), 64'h0);

    // GPR tag 0 consumes no port
    do_reset();
    offer(0, 1'b0, 7'd0, 64'h77);
    offer(1, 1'b0, 7'd9, 64'h99);
    step();
    clear_src();
    chk("tag0_ready0_c1", 64'(bus.src_ready_out[0]), 64'h1);
    step();
    chk("tag0_gpr_v",   64'(bus.gpr_write_valid_out), 64'h1);
    chk("tag0_addr0",   64'(bus.gpr_write_addr_out[0]), 64'd9);
    chk("tag0_data0",   bus.gpr_write_data_out[0], 64'h99);
    chk("tag0_ready_c2", 64'(bus.src_ready_out), 64'h3F);

    // Back-pressure: src 4 denied, holds tag 7 / 0x55
    do_reset();
    for (int i = 0; i < 4; i++) offer(i, 1'b0, TW'(i + 1), DW'(64'h30 + i));
    offer(4, 1'b0, 7'd7, 64'h55);
    step();
    for (int i = 0; i < 4; i++) bus.src_valid_in[i] = 1'b0;
    chk("bp_ready_c1", 64'(bus.src_ready_out), 64'h2F);
    step();
    chk("bp_addr_c2",  64'(bus.gpr_write_addr_out), 64'({7'd4, 7'd3, 7'd2, 7'd1}));
    chk("bp_conf_c2",  64'(bus.wb_conflict_out), 64'h1);
    chk("bp_ready4_c2", 64'(bus.src_ready_out[4]), 64'h1);
    bus.src_valid_in[4] = 1'b0;
    step();
    chk("bp_gpr_v_c3", 64'(bus.gpr_write_valid_out), 64'h1);
    chk("bp_addr0_c3", 64'(bus.gpr_write_addr_out[0]), 64'd7);
    chk("bp_data0_c3", bus.gpr_write_data_out[0], 64'h55);
    chk("bp_conf_c3",  64'(bus.wb_conflict_out), 64'h0);

    // Reset mid-flight with all buffers full and a denial pending
    do_reset();
    for (int i = 0; i < NS; i++) offer(i, 1'b0, TW'(i + 1), DW'(64'h40 + i));
    step();
    rst = 1'b1;
    clear_src();
    step();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("mid_gpr_v", 64'(bus.gpr_write_valid_out), 64'h0);
      chk("mid_fpr_v", 64'(bus.fpr_write_valid_out), 64'h0);
      chk("mid_ready", 64'(bus.src_ready_out), 64'h3F);
      chk("mid_conf",  64'(bus.wb_conflict_out), 64'h0);
      step();
    end
    // rr_ptr back at 0: sources 0-3 win first
    for (int i = 0; i < NS; i++) offer(i, 1'b0, TW'(i + 1), DW'(64'h40 + i));
    step();
    clear_src();
    chk("mid_rr_ready", 64'(bus.src_ready_out), 64'h0F);
    step();
    chk("mid_rr_addr", 64'(bus.gpr_write_addr_out), 64'({7'd4, 7'd3, 7'd2, 7'd1}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/supernova_prf_wb_arbiter.md
# supernova_prf_wb_arbiter

Writeback arbiter between the execution-unit result buses and the write ports of the physical register file. Each of `NUM_SOURCES` functional units hands one result per cycle into a private one-entry holding buffer. Every cycle the arbiter grants up to `NUM_WRITE_PORTS` GPR results and up to `NUM_WRITE_PORTS` FPR results in round-robin order, and drives the PRF write ports from registered outputs. Denied results are held with back-pressure to the source and get top priority in the next cycle.

## Interface
Parameters:
- `NUM_SOURCES`, 6: number of result producers.
- `NUM_WRITE_PORTS`, 4: PRF write ports per file; set equal to `supernova_pkg::COMMIT_WIDTH`.
- `TAG_WIDTH`, `supernova_pkg::GPR_TAG_WIDTH`: physical tag width, shared by GPR and FPR.
- `DATA_WIDTH`, `stu_pkg::REG_WIDTH`: result width.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `src_valid_in`  in  NUM_SOURCES  result offered by source i.
- `src_ready_out`  out  NUM_SOURCES  source i's buffer can accept this cycle.
- `src_is_fp_in`  in  NUM_SOURCES  1 = FPR destination, 0 = GPR.
- `src_tag_in`  in  NUM_SOURCES×TAG_WIDTH  destination physical tag.
- `src_data_in`  in  NUM_SOURCES×DATA_WIDTH  result value.
- `gpr_write_valid_out`, `gpr_write_addr_out`, `gpr_write_data_out`  out  NUM_WRITE_PORTS × (1 / TAG_WIDTH / DATA_WIDTH)  GPR PRF write ports.
- `fpr_write_valid_out`, `fpr_write_addr_out`, `fpr_write_data_out`  out  same shape  FPR PRF write ports.
- `wb_conflict_out`  out  1  pulses for one cycle when at least one buffered result was denied in the previous cycle.

## Operation
- State per source i: `buf_valid[i]`, `buf_is_fp[i]`, `buf_tag[i]`, `buf_data[i]`. Global state: `rr_ptr` of width `$clog2(NUM_SOURCES)`.
- Accept: `src_ready_out[i] = !buf_valid[i] | grant[i]`. When `src_valid_in[i] & src_ready_out[i]`, the buffer loads on the edge.
  - A granted-and-reloaded buffer stays valid with the new content.
  - A granted buffer with no new input clears.
- `grant` is a function of buffer state and `rr_ptr` only. It never depends on `src_valid_in`, so there is no combinational loop.
- Arbitration: scan sources in circular order `rr_ptr, rr_ptr+1, …, rr_ptr+NUM_SOURCES-1` (mod `NUM_SOURCES`).
  - The k-th valid GPR buffer in scan order with k < `NUM_WRITE_PORTS` is granted onto GPR port k.
  - FPR buffers are counted independently and go onto FPR ports the same way.
- GPR tag 0: granted unconditionally and freed. It consumes no port, does not shift port numbering, and produces no write. FPR tag 0 is a normal write.
- Fairness: if any valid buffer is denied, `rr_ptr` takes the index of the first denied buffer in scan order. Otherwise `rr_ptr` is unchanged. A denied result therefore waits at most one cycle per contending class.
- Outputs are registered. Unused ports have valid=0, and their addr/data hold the previous value.
- No two grants in one cycle target the same port. Duplicate destination tags are not checked; they are an upstream error.

## Timing
- Reset values:
  - `buf_valid` = 0, `rr_ptr` = 0.
  - All `*_write_valid_out` = 0, all addr/data outputs = 0, `wb_conflict_out` = 0.
  - `src_ready_out` is all-ones in the first cycle after reset.
- Reset mid-operation: buffered and in-flight results are discarded and no write is issued after the reset edge. Inputs sampled in a cycle with `rst`=1 are ignored.
- Latency with no contention:
  - Handshake in cycle t.
  - Buffer valid and granted in cycle t+1.
  - PRF write valid in cycle t+2; the PRF captures the value on the edge ending t+2.
- Throughput: one result per source per cycle when granted every cycle.
- A denied source sees `src_ready_out`=0 until its buffer is granted. Its input must be held stable.
- `wb_conflict_out` is registered: it is asserted in cycle t+1 for denials in cycle t.

## Test plan
- Single source: source 2 offers GPR tag 5, data 0xAB in cycle 0 → `gpr_write_valid_out[0]`=1, addr 5, data 0xAB in cycle 2; all other valids 0; `src_ready_out[2]` stays 1.
- Contention: all 6 sources offer GPR results (tags 1–6) every cycle, `rr_ptr`=0.
  - Cycle 1 grants sources 0–3 on ports 0–3; `rr_ptr` becomes 4; `wb_conflict_out`=1 in cycle 2.
  - The next cycle grants 4, 5, 0, 1 in that port order.
  - No source waits more than 2 cycles.
- Mixed classes: sources 0–3 GPR and 4–5 FPR, all valid in one cycle → 4 GPR and 2 FPR writes in the same output cycle, with no denial.
- Tag 0: source 0 offers GPR tag 0 and source 1 offers tag 9 → only port 0 is valid, with addr 9; source 0's buffer frees and `src_ready_out[0]` stays 1.
- Back-pressure hold: 5 GPR sources are valid and source 4 is denied. Source 4 holds tag 7, data 0x55 while `src_ready_out[4]`=0 → next cycle source 4 is granted on port 0 with the correct value.
- Reset mid-flight: assert `rst` while all buffers are valid → no write valid in any cycle after the reset edge; `rr_ptr`=0; all ready after reset.
